// File: rtl/config_loader_pkg.sv
// Shared definitions for the fabric config loader and the tiles that decode its bus.
// Address layout: [31:16] sub-block id, [15:0] tile id; all-ones is the idle address.
package config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_DRIVE,
        ST_GAP,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [15:0] CFG_MAGIC     = 16'hC0F6;
    localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

    localparam logic [15:0] CFG_SB  = 16'd7;
    localparam logic [15:0] CFG_CB0 = 16'd6;
    localparam logic [15:0] CFG_CB1 = 16'd5;
    localparam logic [15:0] CFG_CLB = 16'd4;

    function automatic logic [31:0] cfg_make_addr(input logic [15:0] sub_block,
                                                  input logic [15:0] tile_id);
        return {sub_block, tile_id};
    endfunction

endpackage

// File: rtl/config_loader_checksum.sv
// XOR accumulator over a config frame: load on header, fold in each addr/data word.
// Latency: o_match compares the running value against the current word, combinationally.
// Backpressure: none; the loader only strobes it on accepted words.
module config_loader_checksum (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_accum,
    input  logic [31:0] i_word,
    output logic        o_match
);

    logic [31:0] r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= 32'd0;
        end else if (i_load) begin
            r_acc <= i_word;
        end else if (i_accum) begin
            r_acc <= r_acc ^ i_word;
        end
    end

    assign o_match = (r_acc == i_word);

endmodule

// File: rtl/config_loader.sv
// Replays a framed valid/ready word stream as single-cycle config bus writes to all tiles.
// Latency: data word accept -> bus valid one cycle later, held HOLD_CYCLES, then GAP_CYCLES idle.
// Backpressure: in_ready only in IDLE/GET_ADDR/GET_DATA(/CHECK); CONFIG_LOADER_CHECKSUM_EN adds a trailer.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = ST_CHECK;
    localparam logic   END_READY = 1'b1;
`else
    localparam state_t END_STATE = ST_DONE;
    localparam logic   END_READY = 1'b0;
`endif

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   r_remaining;
    logic [15:0]        r_hold_cnt;
    logic [15:0]        r_gap_cnt;
    logic               r_in_ready;
    logic [31:0]        r_config_addr;
    logic [31:0]        r_config_data;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic w_accept;
    logic w_magic_ok;

    assign w_accept   = in_valid && r_in_ready;
    assign w_magic_ok = (in_data[31:16] == CFG_MAGIC);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic w_cks_load;
    logic w_cks_accum;
    logic w_cks_match;

    assign w_cks_load  = w_accept && (r_state == ST_IDLE) && w_magic_ok;
    assign w_cks_accum = w_accept && ((r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA));

    config_loader_checksum u_checksum (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_cks_load),
        .i_accum (w_cks_accum),
        .i_word  (in_data),
        .o_match (w_cks_match)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= 32'd0;
            r_remaining   <= '0;
            r_hold_cnt    <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_in_ready    <= 1'b0;
            r_config_addr <= CFG_IDLE_ADDR;
            r_config_data <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_magic_ok) begin
                            r_error <= 1'b0;
                            if (in_data[15:0] != 16'd0) begin
                                r_state     <= ST_GET_ADDR;
                                r_busy      <= 1'b1;
                                r_remaining <= CNT_W'(in_data[15:0]);
                            end else begin
                                r_state    <= ST_DONE;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            // Bad header is dropped; keep listening for a real one.
                            r_error <= 1'b1;
                        end
                    end
                end

                ST_GET_ADDR: begin
                    if (w_accept) begin
                        r_addr  <= in_data;
                        r_state <= ST_GET_DATA;
                    end
                end

                ST_GET_DATA: begin
                    if (w_accept) begin
                        r_config_addr <= r_addr;
                        r_config_data <= in_data;
                        r_hold_cnt    <= 16'd0;
                        r_in_ready    <= 1'b0;
                        r_state       <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_config_addr <= CFG_IDLE_ADDR;
                        r_remaining   <= r_remaining - CNT_W'(1);
                        r_gap_cnt     <= 16'd0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= ST_GAP;
                        end else if (r_remaining != CNT_W'(1)) begin
                            r_state    <= ST_GET_ADDR;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= END_STATE;
                            r_in_ready <= END_READY;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (r_remaining != '0) begin
                            r_state    <= ST_GET_ADDR;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= END_STATE;
                            r_in_ready <= END_READY;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end

`ifdef CONFIG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept) begin
                        r_error    <= !w_cks_match;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
`endif

                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign config_addr = r_config_addr;
    assign config_data = r_config_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: scoreboard of expected bus writes, popped as writes appear.
module tb_config_loader;
    import config_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] cks;
    logic        prev_write = 1'b0;
    logic [31:0] tile3_sb;

    config_loader #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .config_addr (config_addr),
        .config_data (config_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Tile 3 decoding its switch-box config word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tile3_sb <= 32'd0;
        else if (config_addr == cfg_make_addr(CFG_SB, 16'd3)) tile3_sb <= config_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Bus monitor: every non-idle cycle must be the next expected write, never back to back.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset !== 1'b1) begin
            prev_write = 1'b0;
        end else if (config_addr !== CFG_IDLE_ADDR) begin
            chk("idle_between_writes", {31'd0, prev_write}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_write", config_addr, CFG_IDLE_ADDR);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", config_addr, e[63:32]);
                chk("write_data", config_data, e[31:0]);
            end
            prev_write = 1'b1;
        end else begin
            prev_write = 1'b0;
        end
    end

    task automatic send(input logic [31:0] w, input int max_idle);
        int t;
        t = 0;
        repeat ($urandom_range(0, max_idle)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", t, 32'd0);
        else @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        cks      = cks ^ w;
    endtask

    task automatic send_hdr(input logic [31:0] w);
        cks = 32'd0;
        send(w, 0);
    endtask

    task automatic send_trailer(input logic [31:0] flip);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        logic [31:0] t;
        t = cks ^ flip;
        send(t, 0);
`else
        cks = cks ^ flip;
`endif
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 200);
        if (done !== 1'b1) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cyc;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        cks      = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_addr",  config_addr, 32'hFFFF_FFFF);
        chk("rst_data",  config_data, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b1;

        // 1: single SB write to tile 3
        exp_q.push_back({32'h0007_0003, 32'h0000_0005});
        send_hdr(32'hC0F6_0001);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send(32'h0007_0003, 0);
        send(32'h0000_0005, 0);
        chk("t1_latency_addr", config_addr, 32'h0007_0003);
        chk("t1_latency_data", config_data, 32'h0000_0005);
        send_trailer(32'd0);
        wait_done(cyc);
        chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
        chk("t1_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_tile3_sb", tile3_sb, 32'h0000_0005);

        // 2: empty frame
        send_hdr(32'hC0F6_0000);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        wait_done(cyc);
        chk("t2_done_latency", cyc, 32'd2);
        chk("t2_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t2_done_pulse", {31'd0, done}, 32'd0);

        // 3: bad magic, then a good header clears the error
        send_hdr(32'hDEAD_0002);
        @(negedge clk);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_ready", {31'd0, in_ready}, 32'd1);
        chk("t3_addr_idle", config_addr, CFG_IDLE_ADDR);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // 4: three writes with a stalling source
        exp_q.push_back({32'h0006_0001, 32'h1111_0001});
        exp_q.push_back({32'h0005_0002, 32'h2222_0002});
        exp_q.push_back({32'h0004_0003, 32'h3333_0003});
        send_hdr(32'hC0F6_0003);
        chk("t4_error_cleared", {31'd0, error}, 32'd0);
        send(32'h0006_0001, 3);
        send(32'h1111_0001, 3);
        send(32'h0005_0002, 3);
        send(32'h2222_0002, 3);
        send(32'h0004_0003, 3);
        send(32'h3333_0003, 3);
        send_trailer(32'd0);
        wait_done(cyc);
        chk("t4_all_written", exp_q.size(), 32'd0);
        chk("t4_error", {31'd0, error}, 32'd0);

        // 5: reset in GET_DATA of pair 2 of 4
        exp_q.push_back({32'h0007_0010, 32'hAAAA_0001});
        send_hdr(32'hC0F6_0004);
        send(32'h0007_0010, 0);
        send(32'hAAAA_0001, 0);
        send(32'h0007_0011, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_addr",  config_addr, 32'hFFFF_FFFF);
        chk("t5_data",  config_data, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_busy",  {31'd0, busy}, 32'd0);
        chk("t5_done",  {31'd0, done}, 32'd0);
        chk("t5_pair1_written", exp_q.size(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back({32'h0004_0009, 32'h0000_00AB});
        send_hdr(32'hC0F6_0001);
        send(32'h0004_0009, 0);
        send(32'h0000_00AB, 0);
        send_trailer(32'd0);
        wait_done(cyc);
        chk("t5_reload_written", exp_q.size(), 32'd0);
        chk("t5_reload_error", {31'd0, error}, 32'd0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // 6: corrupted trailer flags an error but still completes
        exp_q.push_back({32'h0005_0007, 32'h0BAD_F00D});
        send_hdr(32'hC0F6_0001);
        send(32'h0005_0007, 0);
        send(32'h0BAD_F00D, 0);
        send_trailer(32'd1);
        wait_done(cyc);
        chk("t6_bad_cks_error", {31'd0, error}, 32'd1);
        chk("t6_written", exp_q.size(), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
